// File: rtl/softmax_grad_unit.sv
// Cross-entropy gradient (p_k - t_k) for a 4-class Q0.8 probability vector, streamed serially.
// Optional argmax / prediction-correct outputs are built when SOFTMAX_GRAD_ARGMAX_EN is defined.
module softmax_grad_unit #(
  parameter int N_CLASS = 4,
  parameter int DATA_W  = 8,
  parameter int LABEL_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [LABEL_W-1:0] in_label,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W:0]    out_grad,
  output logic [LABEL_W-1:0] out_idx,
  output logic               out_last,
  output logic [LABEL_W-1:0] pred_class,
  output logic               pred_correct
);

  localparam logic ST_COLLECT = 1'b0;
  localparam logic ST_EMIT    = 1'b1;

  logic               state;
  logic [LABEL_W-1:0] cnt;
  logic [LABEL_W-1:0] lbl;
  logic [DATA_W-1:0]  buf_q [N_CLASS];
  logic               in_fire;
  logic               out_fire;
  logic               last_cnt;

  // Ready is forced low while reset is held, otherwise a pure decode of the state register.
  assign in_ready  = ~rst & (state == ST_COLLECT);
  assign out_valid = (state == ST_EMIT);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign last_cnt  = (cnt == LABEL_W'(N_CLASS - 1));

  always_comb begin
    out_grad = '0;
    out_idx  = '0;
    out_last = 1'b0;
    if (out_valid) begin
      out_grad = {1'b0, buf_q[cnt]} - ((cnt == lbl) ? (DATA_W+1)'(1 << DATA_W) : '0);
      out_idx  = cnt;
      out_last = last_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_COLLECT;
      cnt   <= '0;
      lbl   <= '0;
      for (int unsigned i = 0; i < N_CLASS; i++) buf_q[i] <= '0;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (in_fire) begin
            buf_q[cnt] <= in_data;
            if (cnt == '0) lbl <= in_label;
            cnt <= cnt + 1'b1;
            if (last_cnt) state <= ST_EMIT;
          end
        end
        default: begin
          if (out_fire) begin
            cnt <= cnt + 1'b1;
            if (last_cnt) state <= ST_COLLECT;
          end
        end
      endcase
    end
  end

`ifdef SOFTMAX_GRAD_ARGMAX_EN
  logic [DATA_W-1:0]  max_val;
  logic [LABEL_W-1:0] max_idx;
  logic [DATA_W-1:0]  nxt_val;
  logic [LABEL_W-1:0] nxt_idx;

  // Strict compare keeps the earliest index on ties; beat 0 always loads.
  always_comb begin
    nxt_val = max_val;
    nxt_idx = max_idx;
    if (cnt == '0 || in_data > max_val) begin
      nxt_val = in_data;
      nxt_idx = cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_val      <= '0;
      max_idx      <= '0;
      pred_class   <= '0;
      pred_correct <= 1'b0;
    end else if (in_fire) begin
      max_val <= nxt_val;
      max_idx <= nxt_idx;
      if (last_cnt) begin
        pred_class   <= nxt_idx;
        pred_correct <= (nxt_idx == lbl);
      end
    end
  end
`else
  assign pred_class   = '0;
  assign pred_correct = 1'b0;
`endif

endmodule

// File: doc/softmax_grad_unit.md
# softmax_grad_unit

Backward-direction companion to the combinational softmax stage: consumes the 4-class probability vector the softmax produces, plus the ground-truth class label. Emits the cross-entropy gradient dL/dz_i = p_i − t_i for each class as a serial valid/ready stream. Sits between the softmax output and the weight-update path of the accelerator. Probabilities are unsigned Q0.8, so 256 represents 1.0.

## Interface
- N_CLASS, 4, classes per vector (fixed at 4; LABEL_W must equal clog2(N_CLASS))
- DATA_W, 8, probability width, unsigned Q0.8
- LABEL_W, 2, label/index width
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  probability beat valid
- in_ready  output  1  unit can accept a probability beat
- in_data  input  DATA_W  probability p_k, class order 0..3
- in_label  input  LABEL_W  true class; sampled only on beat 0 of a vector
- out_valid  output  1  gradient beat valid
- out_ready  input  1  downstream accepts gradient beat
- out_grad  output  DATA_W+1  signed gradient p_k − t_k, two's complement
- out_idx  output  LABEL_W  class index k of current gradient beat
- out_last  output  1  high on beat k = N_CLASS−1
- pred_class  output  LABEL_W  argmax of the vector (see Configuration)
- pred_correct  output  1  pred_class == captured label (see Configuration)

## Operation
- Two states: COLLECT (reset state) and EMIT.
- COLLECT:
  - in_ready=1, out_valid=0.
  - A beat transfers when in_valid&in_ready. in_data is written to buf[cnt], then cnt increments.
  - On the beat with cnt=0, in_label is captured into lbl.
  - On the beat with cnt=3, cnt wraps to 0 and the state moves to EMIT.
- EMIT:
  - in_ready=0; in_valid is ignored and nothing is buffered.
  - out_valid=1, out_idx=cnt, out_last=(cnt==3).
  - out_grad = {1'b0,buf[cnt]} − (cnt==lbl ? 256 : 0), giving a range of −256..+255 in 9 bits.
  - A beat transfers when out_valid&out_ready, then cnt increments.
  - On the transfer with cnt=3, cnt wraps to 0 and the state returns to COLLECT.
- While out_ready=0, out_grad, out_idx and out_last hold stable.
- Values are not clamped and the vector sum is not checked. Any 8-bit value is accepted as a probability.
- Reset at any point:
  - All outputs go to 0 immediately: in_ready=0 while rst is asserted, and in_ready=1 after release.
  - State returns to COLLECT, cnt=0, any partial vector is discarded, and buf and lbl are cleared.

## Timing
- Output reset values: in_ready=0 (during reset), out_valid=0, out_grad=0, out_idx=0, out_last=0, pred_class=0, pred_correct=0.
- Latency: out_valid rises on the cycle after the 4th input beat transfers.
- Maximum throughput is one vector per 8 cycles (4 in + 4 out) when in_valid and out_ready are held high.
- No combinational path from out_ready to in_ready or from in_valid to out_valid. Both ready/valid outputs are decoded from registered state only.
- The input and output phases never overlap. The first input beat of the next vector can transfer on the cycle after the last output beat transfers.

## Configuration
- Macro: SOFTMAX_GRAD_ARGMAX_EN.
- When defined:
  - During COLLECT, a running maximum tracks the value and index. On beat 0 it loads unconditionally.
  - A later beat replaces the maximum only if strictly greater, so ties resolve to the lowest index.
  - pred_class and pred_correct are registered when the state enters EMIT and are held through EMIT until the next vector's EMIT entry.
- When undefined:
  - No compare logic is built.
  - pred_class and pred_correct are tied to 0.

## Test plan
- Uniform vector, no backpressure: inputs 64,64,64,64, label 2 → out_grad +64,+64,−192,+64 with out_idx 0..3 and out_last on beat 3. With ARGMAX_EN: pred_class=0, pred_correct=0.
- Peaked vector: inputs 14,14,56,170, label 3 → out_grad +14,+14,+56,−86. With ARGMAX_EN: pred_class=3, pred_correct=1.
- Backpressure and ignored input:
  - Drop out_ready for 3 cycles during beat 1 → out_grad, out_idx and out_valid are held stable, and no beat is lost.
  - in_valid held high during EMIT → in_ready=0 and no data is captured.
- Ties and extremes:
  - inputs 100,100,28,28, label 1 → pred_class=0, pred_correct=0.
  - inputs 0,0,0,255, label 0 → beat 0 out_grad=−256 (9'h100) and beat 3 out_grad=+255.
- Reset mid-vector: after 2 input beats, assert rst for 1 cycle → all outputs read 0 and in_ready=1 after release. The next 4 beats 64,64,64,64 with label 0 → out_grad −192,+64,+64,+64.
